// File: rtl/rr_grant_scheduler8_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_scheduler8_if
// Description : Request/grant bundle between the requesters and the
//               round-robin scheduler. The master side drives enable and
//               requests. The slave side (the scheduler) returns the grant.
// Revision    : 1.0  initial release
// ============================================================================
interface rr_grant_scheduler8_if;
    logic       EN_L;       // active-low scheduler enable
    logic [7:0] REQ_L;      // active-low requests, bit i = requester i
    logic [7:0] GNT_L;      // active-low one-hot grant
    logic [2:0] GNT_IDX;    // binary index of the current grant
    logic       GNT_VALID;  // high while a grant is held
    logic       TO_PULSE;   // one-cycle pulse on forced timeout release

    modport master (
        output EN_L,
        output REQ_L,
        input  GNT_L,
        input  GNT_IDX,
        input  GNT_VALID,
        input  TO_PULSE
    );

    modport slave (
        input  EN_L,
        input  REQ_L,
        output GNT_L,
        output GNT_IDX,
        output GNT_VALID,
        output TO_PULSE
    );
endinterface
`default_nettype wire

// File: rtl/rr_grant_scheduler8.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_scheduler8
// Description : Eight-way round-robin scheduler with an active-low one-hot
//               grant and a binary grant index. The grant is
//               break-before-make, so every grant is followed by at least
//               one idle cycle. All outputs are registered.
// Options     : GRANT_TIMEOUT_EN - when defined, a grant is force-released
//               after TIMEOUT cycles and TO_PULSE flags the forced release.
// Revision    : 1.0  initial release
// ============================================================================
module rr_grant_scheduler8 #(
    parameter int NREQ    = 8,   // fixed at 8 to match the 3-bit select
    parameter int TIMEOUT = 16   // 2..255, used only with GRANT_TIMEOUT_EN
) (
    input  wire                   CLK,
    input  wire                   RST_L,
    rr_grant_scheduler8_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_gnt_l;
    logic [NREQ-1:0]   w_gnt_l_nxt;
    logic [2:0]        r_gnt_idx;
    logic [2:0]        w_gnt_idx_nxt;
    logic              r_gnt_valid;
    logic              w_gnt_valid_nxt;
    logic              r_to_pulse;
    logic              w_to_pulse_nxt;
    logic [2:0]        r_ptr;
    logic [2:0]        w_ptr_nxt;

    logic [2:0]        w_sel;
    logic              w_any_req;
    logic [2:0]        w_cand;
    logic              w_release_vol;
    logic              w_timeout;

`ifdef GRANT_TIMEOUT_EN
    localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
`endif

    // Pick the first active requester at or after the pointer. The scan runs
    // from the far end so that the last hit is the nearest one to the pointer.
    always_comb begin
        w_sel     = 3'd0;
        w_any_req = 1'b0;
        w_cand    = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = r_ptr + 3'(k);
            if (!bus.REQ_L[w_cand]) begin
                w_sel     = w_cand;
                w_any_req = 1'b1;
            end
        end
    end

    // A voluntary release happens when the holder drops its request or when
    // the scheduler is disabled. A forced release happens when the hold
    // budget is used up.
    always_comb begin
        w_release_vol = bus.REQ_L[r_gnt_idx] | bus.EN_L;
`ifdef GRANT_TIMEOUT_EN
        w_timeout     = (r_cnt == c_to_last);
`else
        w_timeout     = 1'b0;
`endif
    end

    // Next-state and next-output logic. Outputs are precomputed here and then
    // registered, so no input reaches an output combinationally.
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_l_nxt     = r_gnt_l;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_ptr_nxt       = r_ptr;
        w_to_pulse_nxt  = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (!bus.EN_L && w_any_req) begin
                    w_state_nxt     = S_GRANT;
                    w_gnt_l_nxt     = ~(NREQ'(1) << w_sel);
                    w_gnt_idx_nxt   = w_sel;
                    w_gnt_valid_nxt = 1'b1;
`ifdef GRANT_TIMEOUT_EN
                    w_cnt_nxt       = 8'd0;
`endif
                end
            end
            S_GRANT: begin
                if (w_release_vol || w_timeout) begin
                    w_state_nxt     = S_IDLE;
                    w_gnt_l_nxt     = '1;
                    w_gnt_idx_nxt   = 3'd0;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_idx + 3'd1;
                    // A voluntary release at the same edge hides the timeout.
                    w_to_pulse_nxt  = w_timeout && !w_release_vol;
                end
`ifdef GRANT_TIMEOUT_EN
                else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers. The asynchronous reset drops the grant at
    // once, even in the middle of a grant.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_state     <= S_IDLE;
            r_gnt_l     <= '1;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_to_pulse  <= 1'b0;
            r_ptr       <= 3'd0;
`ifdef GRANT_TIMEOUT_EN
            r_cnt       <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_gnt_l     <= w_gnt_l_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_to_pulse  <= w_to_pulse_nxt;
            r_ptr       <= w_ptr_nxt;
`ifdef GRANT_TIMEOUT_EN
            r_cnt       <= w_cnt_nxt;
`endif
        end
    end

    assign bus.GNT_L     = r_gnt_l;
    assign bus.GNT_IDX   = r_gnt_idx;
    assign bus.GNT_VALID = r_gnt_valid;
    assign bus.TO_PULSE  = r_to_pulse;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_scheduler8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_scheduler8
// Description : Directed self-checking bench for rr_grant_scheduler8 with
//               hand-computed expected grants (TIMEOUT = 4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_rr_grant_scheduler8;

    logic r_clk;
    logic r_rst_l;
    int   r_n_tests;
    int   r_n_fail;

    rr_grant_scheduler8_if bus ();

    rr_grant_scheduler8 #(
        .NREQ    (8),
        .TIMEOUT (4)
    ) u_dut (
        .CLK   (r_clk),
        .RST_L (r_rst_l),
        .bus   (bus)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_n_tests++;
        if (got !== exp) begin
            r_n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input int idx);
        logic [7:0] w_exp_l;
        w_exp_l = ~(8'b1 << idx);
        chk({tag, ".gnt_l"}, 32'(bus.GNT_L), 32'(w_exp_l));
        chk({tag, ".idx"},   32'(bus.GNT_IDX), 32'(idx));
        chk({tag, ".valid"}, 32'(bus.GNT_VALID), 32'd1);
        chk({tag, ".to"},    32'(bus.TO_PULSE), 32'd0);
    endtask

    task automatic expect_idle(input string tag, input logic exp_to);
        chk({tag, ".gnt_l"}, 32'(bus.GNT_L), 32'hFF);
        chk({tag, ".idx"},   32'(bus.GNT_IDX), 32'd0);
        chk({tag, ".valid"}, 32'(bus.GNT_VALID), 32'd0);
        chk({tag, ".to"},    32'(bus.TO_PULSE), 32'(exp_to));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        r_n_tests = 0;
        r_n_fail  = 0;
        r_rst_l   = 1'b0;
        bus.EN_L  = 1'b0;
        bus.REQ_L = 8'hFF;

        // Reset held for three cycles with no requests.
        repeat (3) tick();
        expect_idle("reset", 1'b0);
        r_rst_l = 1'b1;
        tick();
        expect_idle("idle_no_req", 1'b0);

        // Single request from requester 2, then release.
        bus.REQ_L = 8'b1111_1011;
        tick();
        expect_grant("single_k", 2);
        tick();
        expect_grant("single_hold", 2);
        bus.REQ_L = 8'hFF;
        tick();
        expect_idle("single_rel", 1'b0);

        // Reset again so rotation starts from pointer 0.
        r_rst_l = 1'b0;
        #1;
        r_rst_l = 1'b1;

        // Rotation: all requesting, each holder releases one cycle after its
        // grant and re-requests after the idle cycle.
        bus.REQ_L = 8'h00;
        for (int i = 0; i < 9; i++) begin
            tick();
            expect_grant($sformatf("rot_g%0d", i), i % 8);
            bus.REQ_L[i % 8] = 1'b1;
            tick();
            expect_idle($sformatf("rot_i%0d", i), 1'b0);
            bus.REQ_L = 8'h00;
        end
        // Pointer is now 1. Move it to 6 via a grant to 5.
        bus.REQ_L = 8'b1101_1111;
        tick();
        expect_grant("to_ptr6", 5);
        bus.REQ_L = 8'hFF;
        tick();
        expect_idle("to_ptr6_rel", 1'b0);

        // Wrap/priority: pointer 6, requesters 0 and 6 (and others ignored
        // once granted).
        bus.REQ_L = 8'b1011_1110;
        tick();
        expect_grant("wrap_6", 6);
        bus.REQ_L = 8'b1000_0000;
        tick();
        expect_grant("wrap_6_others", 6);
        bus.REQ_L = 8'b1111_1110;
        tick();
        expect_idle("wrap_rel6", 1'b0);
        tick();
        expect_grant("wrap_0", 0);
        bus.REQ_L = 8'hFF;
        tick();
        expect_idle("wrap_rel0", 1'b0);

        // Enable high blocks grants and leaves the pointer at 1.
        bus.EN_L  = 1'b1;
        bus.REQ_L = 8'h00;
        tick();
        expect_idle("en_off_a", 1'b0);
        tick();
        expect_idle("en_off_b", 1'b0);
        bus.EN_L = 1'b0;
        tick();
        expect_grant("en_on_ptr", 1);
        bus.REQ_L = 8'hFF;
        tick();
        expect_idle("en_rel1", 1'b0);

        // Enable rising during a grant to 3 releases it; pointer goes to 4.
        bus.REQ_L = 8'b1111_0111;
        tick();
        expect_grant("en_g3", 3);
        bus.EN_L = 1'b1;
        tick();
        expect_idle("en_drop", 1'b0);
        bus.EN_L  = 1'b0;
        bus.REQ_L = 8'h00;
        tick();
        expect_grant("en_ptr4", 4);
        bus.REQ_L = 8'hFF;
        tick();
        expect_idle("en_rel4", 1'b0);

        // Requester 5 holds its request continuously.
        bus.REQ_L = 8'b1101_1111;
        tick();
        expect_grant("to_g0", 5);
`ifdef GRANT_TIMEOUT_EN
        for (int c = 1; c < 4; c++) begin
            tick();
            expect_grant($sformatf("to_g%0d", c), 5);
        end
        tick();
        expect_idle("to_release", 1'b1);
        tick();
        expect_grant("to_regrant", 5);
`else
        for (int c = 1; c < 12; c++) begin
            tick();
            expect_grant($sformatf("hold_g%0d", c), 5);
        end
`endif

        // Asynchronous reset in the middle of a grant drops it at once.
        #2;
        r_rst_l = 1'b0;
        #1;
        chk("async_rst.gnt_l", 32'(bus.GNT_L), 32'hFF);
        chk("async_rst.valid", 32'(bus.GNT_VALID), 32'd0);
        tick();
        r_rst_l   = 1'b1;
        bus.REQ_L = 8'hFF;
        tick();
        expect_idle("post_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", r_n_tests, r_n_fail);
        $finish;
    end

endmodule
`default_nettype wire
